// File: rtl/result_array_decoder.sv
// rtl/result_array_decoder.sv - recovers data byte and op code from a 4-op processor result array.
// Optional macro STRICT_UNIQUE_EN: evaluate all four ops and flag ambiguous matches.
module result_array_decoder #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [0:3][7:0]      array_in,
  input  logic                 array_valid,
  output logic                 array_ready,
  output logic [7:0]           data_out,
  output logic [1:0]           op_out,
  output logic                 decode_err,
  output logic                 ambiguous,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {IDLE, CHECK, OUT} state_t;

  state_t          state;
  logic [0:3][7:0] r;
  logic [1:0]      idx;
  logic [7:0]      cand;
  logic [0:3][7:0] fwd;
  logic            match;
`ifdef STRICT_UNIQUE_EN
  logic            found;
`endif

  assign array_ready = (state == IDLE);

  // Invert the op selected by idx from element 0, then re-run the forward op to confirm.
  always_comb begin
    cand = 8'h00;
    fwd  = '0;
    case (idx)
      2'd0: begin
        cand = r[0] - 8'd1;
        fwd  = {cand + 8'd1, cand + 8'd2, cand + 8'd3, cand + 8'd4};
      end
      2'd1: begin
        cand = {1'b0, r[0][7:1]};
        fwd  = {cand << 1, cand << 2, cand << 3, cand << 4};
      end
      2'd2: begin
        cand = ~r[0];
        fwd  = {~cand, cand & 8'hF0, cand | 8'h0F, cand ^ 8'hFF};
      end
      default: begin
        cand = r[0];
        fwd  = {cand, {cand[6:0], 1'b0}, {1'b0, cand[7:1]}, cand % 8'd10};
      end
    endcase
    match = (fwd == r);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      r          <= '0;
      idx        <= 2'd0;
      data_out   <= 8'h00;
      op_out     <= 2'd0;
      decode_err <= 1'b0;
      ambiguous  <= 1'b0;
      out_valid  <= 1'b0;
      err_count  <= '0;
`ifdef STRICT_UNIQUE_EN
      found      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (array_valid) begin
            r          <= array_in;
            idx        <= 2'd0;
            data_out   <= 8'h00;
            op_out     <= 2'd0;
            decode_err <= 1'b0;
            ambiguous  <= 1'b0;
`ifdef STRICT_UNIQUE_EN
            found      <= 1'b0;
`endif
            state      <= CHECK;
          end
        end
        CHECK: begin
`ifdef STRICT_UNIQUE_EN
          if (match) begin
            if (!found) begin
              found    <= 1'b1;
              data_out <= cand;
              op_out   <= idx;
            end else begin
              ambiguous <= 1'b1;
            end
          end
          if (idx == 2'd3) begin
            if (!found && !match) decode_err <= 1'b1;
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            idx <= idx + 2'd1;
          end
`else
          if (match) begin
            data_out  <= cand;
            op_out    <= idx;
            out_valid <= 1'b1;
            state     <= OUT;
          end else if (idx == 2'd3) begin
            data_out   <= 8'h00;
            op_out     <= 2'd0;
            decode_err <= 1'b1;
            out_valid  <= 1'b1;
            state      <= OUT;
          end else begin
            idx <= idx + 2'd1;
          end
`endif
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
            if (decode_err && (err_count != {ERR_CNT_W{1'b1}}))
              err_count <= err_count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_array_decoder.sv
// tb/tb_result_array_decoder.sv - directed bench for result_array_decoder.
module tb_result_array_decoder;

  logic            clk = 1'b0;
  logic            rst;
  logic [0:3][7:0] array_in;
  logic            array_valid;
  logic            array_ready;
  logic [7:0]      data_out;
  logic [1:0]      op_out;
  logic            decode_err;
  logic            ambiguous;
  logic            out_valid;
  logic            out_ready;
  logic [7:0]      err_count;

  int errors = 0;
  int checks = 0;

  result_array_decoder #(.ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .array_in(array_in), .array_valid(array_valid),
    .array_ready(array_ready), .data_out(data_out), .op_out(op_out),
    .decode_err(decode_err), .ambiguous(ambiguous), .out_valid(out_valid),
    .out_ready(out_ready), .err_count(err_count)
  );

  always #5 clk = ~clk;

`ifdef STRICT_UNIQUE_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply(input logic [7:0] a0, a1, a2, a3, output int lat);
    @(negedge clk);
    array_in    = {a0, a1, a2, a3};
    array_valid = 1'b1;
    @(posedge clk);
    #1;
    array_valid = 1'b0;
    array_in    = {8'hA5, 8'h5A, 8'hFF, 8'h11};
    lat = 99;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_case(input string tag, input logic [7:0] a0, a1, a2, a3,
                          input logic [7:0] e_data, input logic [1:0] e_op,
                          input logic e_err, input logic e_amb, input int e_lat);
    int lat;
    apply(a0, a1, a2, a3, lat);
    check_eq({tag, " latency"}, lat, STRICT ? 4 : e_lat);
    check_eq({tag, " data"}, data_out, e_data);
    check_eq({tag, " op"}, op_out, e_op);
    check_eq({tag, " err"}, decode_err, e_err);
    check_eq({tag, " amb"}, ambiguous, e_amb);
    drain();
    check_eq({tag, " valid_low"}, out_valid, 1'b0);
    check_eq({tag, " ready_back"}, array_ready, 1'b1);
  endtask

  initial begin
    int lat;
    logic [7:0] hold_data;
    logic [1:0] hold_op;
    rst = 1'b1;
    array_in = '0;
    array_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset ready", array_ready, 1'b1);
    check_eq("reset valid", out_valid, 1'b0);
    check_eq("reset data", data_out, 8'h00);
    check_eq("reset op", op_out, 2'd0);
    check_eq("reset flags", {decode_err, ambiguous}, 2'b00);
    check_eq("reset errcnt", err_count, 8'd0);
    @(negedge clk);
    rst = 1'b0;

    run_case("t1", 8'h06, 8'h07, 8'h08, 8'h09, 8'h05, 2'd0, 1'b0, 1'b0, 1);
    run_case("t2", 8'h06, 8'h0C, 8'h18, 8'h30, 8'h03, 2'd1, 1'b0, 1'b0, 2);
    run_case("t3", 8'hC3, 8'h30, 8'h3F, 8'hC3, 8'h3C, 2'd2, 1'b0, 1'b0, 3);
    run_case("t4", 8'h17, 8'h2E, 8'h0B, 8'h03, 8'h17, 2'd3, 1'b0, 1'b0, 4);
    check_eq("t4 errcnt", err_count, 8'd0);
    run_case("t5", 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 2'd0, 1'b1, 1'b0, 4);
    check_eq("t5 errcnt", err_count, 8'd1);

    for (int i = 0; i < 254; i++) begin
      apply(8'h00, 8'h00, 8'h00, 8'h01, lat);
      drain();
    end
    check_eq("sat errcnt", err_count, 8'hFF);
    run_case("t5b", 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 2'd0, 1'b1, 1'b0, 4);
    check_eq("t5b errcnt hold", err_count, 8'hFF);

    run_case("t6", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'd1, 1'b0, STRICT, 2);

    // Hold the result while new arrays are offered; none may be taken.
    apply(8'hC3, 8'h30, 8'h3F, 8'hC3, lat);
    check_eq("t7 valid", out_valid, 1'b1);
    hold_data = data_out;
    hold_op = op_out;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      array_in = {8'h06, 8'h07, 8'h08, 8'h09};
      array_valid = (i % 2 == 0);
      check_eq("t7 ready low", array_ready, 1'b0);
      check_eq("t7 data stable", data_out, 8'h3C);
      check_eq("t7 op stable", op_out, 2'd2);
      check_eq("t7 valid held", out_valid, 1'b1);
    end
    @(negedge clk);
    array_valid = 1'b0;
    check_eq("t7 hold data", data_out, hold_data);
    check_eq("t7 hold op", op_out, hold_op);
    drain();
    repeat (3) @(posedge clk);
    #1;
    check_eq("t7 no ghost", out_valid, 1'b0);
    check_eq("t7 idle", array_ready, 1'b1);

    @(negedge clk);
    array_in = {8'h17, 8'h2E, 8'h0B, 8'h03};
    array_valid = 1'b1;
    @(posedge clk);
    #1;
    array_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("t7b rst ready", array_ready, 1'b1);
    check_eq("t7b rst valid", out_valid, 1'b0);
    check_eq("t7b rst errcnt", err_count, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("t7b dropped", out_valid, 1'b0);
    run_case("t7b next", 8'h06, 8'h0C, 8'h18, 8'h30, 8'h03, 2'd1, 1'b0, 1'b0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
